// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller: decodes peripheral byte addresses onto N single-port
// macros and returns in-order responses with 1 or 2 cycles of latency.
module sram_bank_ctrl #(
    parameter int NUM_BANKS = 7,
    parameter int BANK_AW   = 10,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int OUT_REG   = 0,
    parameter logic [DATA_W-1:0] OOR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [DATA_W/8-1:0]         be_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        err_o,
    output logic [15:0]                 err_cnt_o,
    output logic [NUM_BANKS-1:0]        sram_men_o,
    output logic                        sram_wen_o,
    output logic                        sram_ren_o,
    output logic [BANK_AW-1:0]          sram_addr_o,
    output logic [DATA_W-1:0]           sram_bm_o,
    output logic [DATA_W-1:0]           sram_din_o,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_dout_i
);

    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BE_W     = DATA_W / 8;
    localparam int BANK_LSB = BANK_AW + 2;
    localparam int TOP_LSB  = BANK_LSB + BW;

    logic [BANK_AW-1:0] word;
    logic [BW-1:0]      bank;
    logic               hi_set;
    logic               oor;
    logic               accepted;
    logic               bank_hit;
    logic [DATA_W-1:0]  bm;

    // Bank field sits directly above the word field; anything above it is out of range.
    assign word = addr_i[BANK_LSB-1:2];
    assign bank = addr_i[BANK_LSB +: BW];

    generate
        if (TOP_LSB < ADDR_W) begin : g_hi
            assign hi_set = |addr_i[ADDR_W-1:TOP_LSB];
        end else begin : g_no_hi
            assign hi_set = 1'b0;
        end
    endgenerate

    assign oor      = hi_set || (int'(bank) >= NUM_BANKS);
    assign accepted = req_i & gnt_o;
    assign bank_hit = accepted & ~oor & (we_i ? |be_i : 1'b1);

    generate
        for (genvar i = 0; i < BE_W; i++) begin : g_bm
            assign bm[i*8 +: 8] = {8{be_i[i]}};
        end
    endgenerate

    always_comb begin
        sram_men_o = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            sram_men_o[k] = bank_hit && (bank == BW'(k));
        end
    end

    // Everything toward the macros is held at zero until the grant comes up.
    assign sram_wen_o  = gnt_o & we_i;
    assign sram_ren_o  = gnt_o & ~we_i;
    assign sram_addr_o = gnt_o ? word    : '0;
    assign sram_bm_o   = gnt_o ? bm      : '0;
    assign sram_din_o  = gnt_o ? wdata_i : '0;

    logic          v1;
    logic [BW-1:0] bank1;
    logic          oor1;
    logic          rd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_o     <= 1'b0;
            v1        <= 1'b0;
            bank1     <= '0;
            oor1      <= 1'b0;
            rd1       <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            gnt_o <= 1'b1;
            v1    <= accepted;
            bank1 <= bank;
            oor1  <= oor;
            rd1   <= ~we_i;
            if (accepted && oor && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

    logic [DATA_W-1:0] bank_dout [NUM_BANKS];
    logic [DATA_W-1:0] bank_data;
    logic [DATA_W-1:0] rdata0;
    logic              err0;

    generate
        for (genvar k = 0; k < NUM_BANKS; k++) begin : g_dout
            assign bank_dout[k] = sram_dout_i[k*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        bank_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank1 == BW'(k)) bank_data = bank_dout[k];
        end
    end

    always_comb begin
        rdata0 = '0;
        if (rd1) rdata0 = oor1 ? OOR_DATA : bank_data;
    end

    assign err0 = v1 & oor1;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid_o <= 1'b0;
                    rdata_o  <= '0;
                    err_o    <= 1'b0;
                end else begin
                    rvalid_o <= v1;
                    rdata_o  <= rdata0;
                    err_o    <= err0;
                end
            end
        end else begin : g_out_comb
            assign rvalid_o = v1;
            assign rdata_o  = rdata0;
            assign err_o    = err0;
        end
    endgenerate

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: 7-bank latency-1 and 4-bank latency-2 instances,
// each backed by a behavioural macro model, responses checked via scoreboards.
module tb_sram_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    resp_t sb_a[$];
    resp_t sb_b[$];

    // ---------------- instance A: 7 banks, latency 1 ----------------
    logic          rst_n_a, req_a, we_a, gnt_a, rvalid_a, err_a, wen_a, ren_a;
    logic [3:0]    be_a;
    logic [23:0]   addr_a;
    logic [31:0]   wdata_a, rdata_a, bm_a, din_a;
    logic [15:0]   err_cnt_a;
    logic [6:0]    men_a;
    logic [7:0]    saddr_a;
    logic [223:0]  dout_a;

    sram_bank_ctrl #(.NUM_BANKS(7), .BANK_AW(8), .ADDR_W(24), .DATA_W(32), .OUT_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .req_i(req_a), .we_i(we_a), .be_i(be_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a), .err_cnt_o(err_cnt_a), .sram_men_o(men_a),
        .sram_wen_o(wen_a), .sram_ren_o(ren_a), .sram_addr_o(saddr_a),
        .sram_bm_o(bm_a), .sram_din_o(din_a), .sram_dout_i(dout_a)
    );

    // ---------------- instance B: 4 banks, latency 2 ----------------
    logic          rst_n_b, req_b, we_b, gnt_b, rvalid_b, err_b, wen_b, ren_b;
    logic [3:0]    be_b;
    logic [23:0]   addr_b;
    logic [31:0]   wdata_b, rdata_b, bm_b, din_b;
    logic [15:0]   err_cnt_b;
    logic [3:0]    men_b;
    logic [7:0]    saddr_b;
    logic [127:0]  dout_b;

    sram_bank_ctrl #(.NUM_BANKS(4), .BANK_AW(8), .ADDR_W(24), .DATA_W(32), .OUT_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req_i(req_b), .we_i(we_b), .be_i(be_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b), .err_cnt_o(err_cnt_b), .sram_men_o(men_b),
        .sram_wen_o(wen_b), .sram_ren_o(ren_b), .sram_addr_o(saddr_b),
        .sram_bm_o(bm_b), .sram_din_o(din_b), .sram_dout_i(dout_b)
    );

    // ---------------- macro models (1-cycle read) ----------------
    logic [31:0] mem_a [7][256];
    logic [31:0] q_a   [7];
    logic [31:0] mem_b [4][256];
    logic [31:0] q_b   [4];

    initial begin
        for (int k = 0; k < 7; k++) begin
            q_a[k] = '0;
            for (int w = 0; w < 256; w++) mem_a[k][w] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            q_b[k] = '0;
            for (int w = 0; w < 256; w++) mem_b[k][w] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 7; k++) begin
            if (men_a[k]) begin
                if (wen_a) mem_a[k][saddr_a] <= (mem_a[k][saddr_a] & ~bm_a) | (din_a & bm_a);
                else       q_a[k] <= mem_a[k][saddr_a];
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (men_b[k]) begin
                if (wen_b) mem_b[k][saddr_b] <= (mem_b[k][saddr_b] & ~bm_b) | (din_b & bm_b);
                else       q_b[k] <= mem_b[k][saddr_b];
            end
        end
    end

    always_comb begin
        dout_a = '0;
        for (int k = 0; k < 7; k++) dout_a[k*32 +: 32] = q_a[k];
    end

    always_comb begin
        dout_b = '0;
        for (int k = 0; k < 4; k++) dout_b[k*32 +: 32] = q_b[k];
    end

    // ---------------- response monitors ----------------
    initial forever begin
        @(negedge clk);
        if (rvalid_a) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_rvalid", 1, 0);
            end else begin
                resp_t e;
                e = sb_a.pop_front();
                chk("a_rdata", rdata_a, e.rdata);
                chk("a_err", err_a, e.err);
                chk("a_latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rvalid_b) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_rvalid", 1, 0);
            end else begin
                resp_t e;
                e = sb_b.pop_front();
                chk("b_rdata", rdata_b, e.rdata);
                chk("b_err", err_b, e.err);
                chk("b_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain(input bit is_b);
        for (int i = 0; i < 12 && ((is_b ? sb_b.size() : sb_a.size()) > 0); i++) @(negedge clk);
        #2;
        if (is_b) chk("b_scoreboard_drained", sb_b.size(), 0);
        else      chk("a_scoreboard_drained", sb_a.size(), 0);
    endtask

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [6:0]  men;
        logic [31:0] bm;
        logic [7:0]  word;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    initial begin
        vec[0]  = '{1'b1, 4'hF, 24'h001404, 32'hA5A51234, 7'b0100000, 32'hFFFFFFFF, 8'd1, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 4'hF, 24'h001404, 32'h0,        7'b0100000, 32'hFFFFFFFF, 8'd1, 32'hA5A51234, 1'b0};
        vec[2]  = '{1'b1, 4'h5, 24'h000008, 32'h11223344, 7'b0000001, 32'h00FF00FF, 8'd2, 32'h0,        1'b0};
        vec[3]  = '{1'b0, 4'hF, 24'h000008, 32'h0,        7'b0000001, 32'hFFFFFFFF, 8'd2, 32'h00220044, 1'b0};
        vec[4]  = '{1'b1, 4'h0, 24'h000C10, 32'hCAFEF00D, 7'b0000000, 32'h00000000, 8'd4, 32'h0,        1'b0};
        vec[5]  = '{1'b0, 4'hF, 24'h000C10, 32'h0,        7'b0001000, 32'hFFFFFFFF, 8'd4, 32'h0,        1'b0};
        vec[6]  = '{1'b0, 4'hF, 24'h001C00, 32'h0,        7'b0000000, 32'hFFFFFFFF, 8'd0, 32'hDEADBEEF, 1'b1};
        vec[7]  = '{1'b0, 4'hF, 24'h010000, 32'h0,        7'b0000000, 32'hFFFFFFFF, 8'd0, 32'hDEADBEEF, 1'b1};
        vec[8]  = '{1'b1, 4'h8, 24'h001800, 32'h0F0F0F0F, 7'b1000000, 32'hFF000000, 8'd0, 32'h0,        1'b0};
        vec[9]  = '{1'b0, 4'hF, 24'h001800, 32'h0,        7'b1000000, 32'hFFFFFFFF, 8'd0, 32'h0F000000, 1'b0};
        vec[10] = '{1'b1, 4'hF, 24'h001C04, 32'h12345678, 7'b0000000, 32'hFFFFFFFF, 8'd1, 32'h0,        1'b1};

        rst_n_a = 0; req_a = 0; we_a = 0; be_a = 0; addr_a = 0; wdata_a = 0;
        rst_n_b = 0; req_b = 0; we_b = 0; be_b = 0; addr_b = 0; wdata_b = 0;

        // reset and release
        repeat (3) @(negedge clk);
        chk("a_reset_gnt", gnt_a, 0);
        chk("a_reset_rvalid", rvalid_a, 0);
        chk("a_reset_err_cnt", err_cnt_a, 0);
        chk("b_reset_gnt", gnt_b, 0);
        chk("b_reset_rvalid", rvalid_b, 0);
        rst_n_a = 1; rst_n_b = 1;
        #1 chk("a_gnt_before_edge", gnt_a, 0);
        @(negedge clk);
        chk("a_gnt_after_release", gnt_a, 1);
        chk("b_gnt_after_release", gnt_b, 1);

        // table, back-to-back on instance A
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req_a = 1; we_a = vec[i].we; be_a = vec[i].be;
            addr_a = vec[i].addr; wdata_a = vec[i].wdata;
            sb_a.push_back('{vec[i].rdata, vec[i].err, cyc + 1});
            #1;
            chk($sformatf("a_men[%0d]", i), men_a, vec[i].men);
            chk($sformatf("a_bm[%0d]", i), bm_a, vec[i].bm);
            chk($sformatf("a_word[%0d]", i), saddr_a, vec[i].word);
            chk($sformatf("a_wen[%0d]", i), wen_a, vec[i].we);
            chk($sformatf("a_ren[%0d]", i), ren_a, !vec[i].we);
            if (vec[i].we) chk($sformatf("a_din[%0d]", i), din_a, vec[i].wdata);
        end
        @(negedge clk);
        req_a = 0;
        drain(0);
        chk("a_err_cnt_after_table", err_cnt_a, 3);

        // saturation: preload the counter just below the top
        @(negedge clk);
        force dut_a.err_cnt_o = 16'hFFFE;
        #1 release dut_a.err_cnt_o;
        req_a = 1; we_a = 0; be_a = 4'hF; addr_a = 24'h001C00;
        sb_a.push_back('{32'hDEADBEEF, 1'b1, cyc + 1});
        @(negedge clk);
        chk("a_err_cnt_reaches_max", err_cnt_a, 16'hFFFF);
        we_a = 1; addr_a = 24'h020000; wdata_a = 32'h55AA55AA;
        sb_a.push_back('{32'h0, 1'b1, cyc + 1});
        #1 chk("a_men_oor_high_bit", men_a, 0);
        @(negedge clk);
        req_a = 0;
        chk("a_err_cnt_saturated", err_cnt_a, 16'hFFFF);
        drain(0);

        // instance B: fill banks 0..3, then 4 back-to-back reads
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_b = 1; we_b = 1; be_b = 4'hF;
            addr_b = 24'(k) << 10; wdata_b = 32'hB0B00000 + 32'(k);
            sb_b.push_back('{32'h0, 1'b0, cyc + 2});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            we_b = 0; addr_b = (24'(k) << 10) | 24'h4;
            sb_b.push_back('{32'h0, 1'b0, cyc + 2});
            #1 chk($sformatf("b_men_read%0d", k), men_b, 4'b0001 << k);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            addr_b = 24'(k) << 10;
            sb_b.push_back('{32'hB0B00000 + 32'(k), 1'b0, cyc + 2});
        end
        @(negedge clk);
        addr_b = 24'h001000;
        sb_b.push_back('{32'hDEADBEEF, 1'b1, cyc + 2});
        #1 chk("b_men_oor", men_b, 0);
        @(negedge clk);
        req_b = 0;
        drain(1);
        chk("b_err_cnt", err_cnt_b, 1);

        // reset while a read is in flight
        @(negedge clk);
        req_b = 1; we_b = 0; be_b = 4'hF; addr_b = 24'h000400;
        @(negedge clk);
        rst_n_b = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_midreset_rvalid", rvalid_b, 0);
            chk("b_midreset_gnt", gnt_b, 0);
            chk("b_midreset_men", men_b, 0);
        end
        chk("b_midreset_err_cnt", err_cnt_b, 0);
        req_b = 0; rst_n_b = 1;
        #1 chk("b_gnt_before_edge", gnt_b, 0);
        @(negedge clk);
        chk("b_gnt_after_release", gnt_b, 1);
        chk("b_rvalid_after_release", rvalid_b, 0);
        repeat (2) @(negedge clk);
        #2 chk("b_scoreboard_empty", sb_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

endmodule
